// File: rtl/coord_emitter.sv
// Serializes a captured 4-bit X / 4-bit Y board coordinate LSB-first, X field first, as timed show/gap bit slots.
// Optional COORD_PARITY_EN adds a ninth slot carrying even parity over all eight coordinate bits.
module coord_emitter #(
   parameter int unsigned BIT_CYCLES = 4,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] x_in,
   input  logic [3:0] y_in,
   output logic       ready,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       field,
   output logic [3:0] bit_count,
   output logic       done,
   output logic [1:0] state
);

   localparam int unsigned TICK_W = 4;
   localparam int unsigned CNT_W  = 4;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_X_OUT = 2'b01;
   localparam logic [1:0] S_Y_OUT = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   localparam logic [TICK_W-1:0] SHOW_LAST = TICK_W'(BIT_CYCLES - 1);
   localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  X_LAST    = CNT_W'(3);
`ifdef COORD_PARITY_EN
   localparam logic [CNT_W-1:0]  Y_LAST    = CNT_W'(8);
`else
   localparam logic [CNT_W-1:0]  Y_LAST    = CNT_W'(7);
`endif

   logic [1:0]        state_n;
   logic              ready_n;
   logic              bit_out_n;
   logic              bit_valid_n;
   logic              field_n;
   logic [CNT_W-1:0]  bit_count_n;
   logic              done_n;
   logic [3:0]        x_sh, x_sh_n;
   logic [3:0]        y_sh, y_sh_n;
   logic [TICK_W-1:0] tick, tick_n;
   logic              in_gap, in_gap_n;
   logic [CNT_W-1:0]  next_slot;

   // Bit shown in slot idx: X bits 0..3, Y bits 4..7, parity at 8 when enabled.
   function automatic logic slot_bit(input logic [CNT_W-1:0] idx,
                                     input logic [3:0] xs,
                                     input logic [3:0] ys);
      logic b;
      b = 1'b0;
      if (idx < CNT_W'(4))
         b = xs[idx[1:0]];
      else if (idx < CNT_W'(8))
         b = ys[idx[1:0]];
`ifdef COORD_PARITY_EN
      else
         b = ^{xs, ys};
`endif
      return b;
   endfunction

   assign next_slot = bit_count + CNT_W'(1);

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         ready     <= 1'b1;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         field     <= 1'b0;
         bit_count <= '0;
         done      <= 1'b0;
         x_sh      <= '0;
         y_sh      <= '0;
         tick      <= '0;
         in_gap    <= 1'b0;
      end else begin
         state     <= state_n;
         ready     <= ready_n;
         bit_out   <= bit_out_n;
         bit_valid <= bit_valid_n;
         field     <= field_n;
         bit_count <= bit_count_n;
         done      <= done_n;
         x_sh      <= x_sh_n;
         y_sh      <= y_sh_n;
         tick      <= tick_n;
         in_gap    <= in_gap_n;
      end
   end

   // Next state and next output values; outputs for cycle n+1 are decided at edge n.
   always_comb begin
      state_n     = state;
      bit_out_n   = 1'b0;
      bit_valid_n = 1'b0;
      field_n     = field;
      bit_count_n = bit_count;
      done_n      = 1'b0;
      x_sh_n      = x_sh;
      y_sh_n      = y_sh;
      tick_n      = tick;
      in_gap_n    = in_gap;

      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               state_n     = S_X_OUT;
               x_sh_n      = x_in;
               y_sh_n      = y_in;
               bit_count_n = '0;
               tick_n      = '0;
               in_gap_n    = 1'b0;
               field_n     = 1'b0;
               bit_valid_n = 1'b1;
               bit_out_n   = x_in[0];
            end
         end

         S_X_OUT, S_Y_OUT: begin
            if (abort) begin
               state_n  = S_IDLE;
               field_n  = 1'b0;
               tick_n   = '0;
               in_gap_n = 1'b0;
            end else if (!in_gap) begin
               if (tick == SHOW_LAST) begin
                  in_gap_n = 1'b1;
                  tick_n   = '0;
               end else begin
                  tick_n      = tick + TICK_W'(1);
                  bit_valid_n = 1'b1;
                  bit_out_n   = slot_bit(bit_count, x_sh, y_sh);
               end
            end else if (tick != GAP_LAST) begin
               tick_n = tick + TICK_W'(1);
            end else begin
               // Slot boundary: count it, then either open the next slot or finish.
               tick_n      = '0;
               in_gap_n    = 1'b0;
               bit_count_n = next_slot;
               if ((state == S_Y_OUT) && (bit_count == Y_LAST)) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end else begin
                  if ((state == S_X_OUT) && (bit_count == X_LAST)) begin
                     state_n = S_Y_OUT;
                     field_n = 1'b1;
                  end
                  bit_valid_n = 1'b1;
                  bit_out_n   = slot_bit(next_slot, x_sh, y_sh);
               end
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
            field_n = 1'b0;
         end

         default: begin
            state_n = S_IDLE;
            field_n = 1'b0;
         end
      endcase

      ready_n = (state_n == S_IDLE);
   end

endmodule

// File: doc/coord_emitter.md
# coord_emitter

Serializes a validated board coordinate (4-bit X, 4-bit Y) into a timed bit stream on a single indicator output, so the game can replay a move back to the players. It sits between the game logic, which issues a start strobe with the coordinate, and the board LED/feedback driver. Bits are emitted in the same order players enter them: LSB first, X field before Y field.

## Interface
- BIT_CYCLES, 4: cycles each bit is shown (bit_valid high); legal range 1..15
- GAP_CYCLES, 2: idle cycles after each bit (bit_valid low); legal range 1..15
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request strobe; accepted only on an edge where ready=1
- abort  in  1  synchronous cancel of a transfer in progress
- x_in  in  4  X coordinate, captured on acceptance
- y_in  in  4  Y coordinate, captured on acceptance
- ready  out  1  high in IDLE only
- bit_out  out  1  current bit value; 0 whenever bit_valid=0
- bit_valid  out  1  high during the show phase of a bit slot
- field  out  1  0 = X field, 1 = Y field (1 also for the parity slot)
- bit_count  out  4  number of slots completed in the current transfer
- done  out  1  one-cycle pulse after the last slot
- state  out  2  IDLE=00, X_OUT=01, Y_OUT=10, DONE=11

## Operation
- Reset: state=IDLE, ready=1, bit_out=0, bit_valid=0, field=0, bit_count=0, done=0; shadow registers and tick counter cleared.
- IDLE: on start=1 and abort=0, capture x_in/y_in into shadow registers, clear bit_count and the tick counter, go to X_OUT. abort=1 in IDLE: no effect, start is ignored on that edge.
- Bit slot = BIT_CYCLES show cycles (bit_valid=1, bit_out = shadow bit) followed by GAP_CYCLES gap cycles (bit_valid=0, bit_out=0). bit_count increments on the last gap cycle of each slot.
- X_OUT: slots for x[0], x[1], x[2], x[3]; after the 4th slot go to Y_OUT, field=1.
- Y_OUT: slots for y[0]..y[3]; after the 4th slot go to DONE (or emit the parity slot, see Configuration).
- DONE: done=1 for exactly one cycle; next state IDLE. bit_count holds its final value until the next acceptance.
- abort=1 in X_OUT/Y_OUT/DONE: next state IDLE; bit_valid=0, bit_out=0, no done pulse; bit_count holds.
- start while not in IDLE is ignored; x_in/y_in changes after acceptance do not affect the output.
- Reset mid-transfer: immediate return to reset values; no done pulse.

## Timing
- Acceptance edge = cycle 0. First show cycle is cycle 1 (registered outputs, one-cycle latency).
- Slot k (k = 0..7) show cycles: k*(B+G)+1 .. k*(B+G)+B; gap cycles: k*(B+G)+B+1 .. (k+1)*(B+G), with B=BIT_CYCLES, G=GAP_CYCLES.
- field rises at the first show cycle of slot 4.
- done high in cycle 8*(B+G)+1; ready high again in cycle 8*(B+G)+2. Defaults: done in cycle 49, ready in cycle 50.
- abort sampled high at edge n: outputs at IDLE values from cycle n+1; ready=1 from cycle n+1.
- The tick counter is 4 bits wide and reloads per phase; it does not wrap within a phase for legal parameter values.

## Configuration
- COORD_PARITY_EN defined: after the Y field, one extra slot (still in Y_OUT, field=1) carries even parity = XOR of all 8 coordinate bits. bit_count reaches 9. done in cycle 9*(B+G)+1 (defaults: 55).
- Not defined: 8 slots only, bit_count reaches 8, timing as above; no parity logic is synthesized.

## Test plan
- Reset then idle: reset pulse mid-cycle -> all outputs at reset values immediately; ready=1, state=00.
- Nominal transfer, defaults, x_in=4'b1010, y_in=4'b0011, start at cycle 0 -> bit_out during shows = 0,1,0,1,1,1,0,0; each show is 4 cycles, each gap 2 cycles; field=1 from cycle 25; done=1 only in cycle 49; bit_count=8.
- Input hold-off: change x_in and pulse start at cycle 10 of a transfer -> stream unchanged, done still at cycle 49 only.
- Abort in Y field: abort at cycle 30 -> bit_valid=0 and state=00 from cycle 31, no done pulse, bit_count=4; a new start at cycle 32 is accepted.
- Reset mid-transfer: reset at cycle 20 -> outputs at reset values immediately; no done; a new start after release produces a full, correct stream.
- With COORD_PARITY_EN, x_in=4'b0111, y_in=4'b0001 -> 9th slot bit_out=0 (even parity over 4 set bits), done in cycle 55, bit_count=9.
